// File: rtl/midi_out_tx_pkg.sv
// MIDI status constants, message FSM encoding and length decode for the MIDI OUT path.
package midi_pkg;

  localparam logic [7:0] NOTE_OFF = 8'h80;
  localparam logic [7:0] NOTE_ON  = 8'h90;
  localparam logic [7:0] POLY_AT  = 8'hA0;
  localparam logic [7:0] CC       = 8'hB0;
  localparam logic [7:0] PROG     = 8'hC0;
  localparam logic [7:0] CHAN_AT  = 8'hD0;
  localparam logic [7:0] PITCH    = 8'hE0;
  localparam logic [7:0] RT_BASE  = 8'hF8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_START,
    ST_DATA,
    ST_STOP
  } state_t;

  // 0 means the status cannot be sent (data byte, sysex/common range)
  function automatic logic [1:0] msg_len(input logic [7:0] s);
    logic [1:0] n;
    n = 2'd0;
    case ({s[7:4], 4'h0})
      NOTE_OFF, NOTE_ON, POLY_AT, CC, PITCH: n = 2'd3;
      PROG, CHAN_AT:                         n = 2'd2;
      8'hF0:                                 n = (s >= RT_BASE) ? 2'd1 : 2'd0;
      default:                               n = 2'd0;
    endcase
    return n;
  endfunction

  function automatic logic is_chan_voice(input logic [7:0] s);
    return (s >= NOTE_OFF) && (s < 8'hF0);
  endfunction

endpackage

// File: rtl/midi_out_tx_if.sv
// Message handshake between a MIDI message source (master) and the transmitter (slave).
interface midi_out_tx_if;
  logic       IN_MSG_VALID;
  logic       OUT_MSG_READY;
  logic [7:0] IN_STATUS;
  logic [6:0] IN_DATA1;
  logic [6:0] IN_DATA2;

  modport master (output IN_MSG_VALID, output IN_STATUS, output IN_DATA1, output IN_DATA2,
                  input  OUT_MSG_READY);
  modport slave  (input  IN_MSG_VALID, input  IN_STATUS, input  IN_DATA1, input  IN_DATA2,
                  output OUT_MSG_READY);
endinterface

// File: rtl/midi_out_tx_uart_tx_byte.sv
// One 8N1 UART frame per start strobe; o_done fires one cycle before the stop bit ends so a
// strobe in that final stop cycle chains the next frame with no idle gap.
module uart_tx_byte #(
  parameter int CLKS_PER_BIT = 1600
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_byte,
  output logic       o_tx,
  output logic       o_bit_end,
  output logic       o_done
);

  localparam int             CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]  CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]  CNT_PRE  = CW'(CLKS_PER_BIT - 2);

  logic [9:0]    r_shift;
  logic [CW-1:0] r_cnt;
  logic [3:0]    r_bits_left;
  logic          r_active;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shift     <= '1;
      r_cnt       <= '0;
      r_bits_left <= '0;
      r_active    <= 1'b0;
    end else if (i_start) begin
      r_shift     <= {1'b1, i_byte, 1'b0};
      r_cnt       <= '0;
      r_bits_left <= 4'd10;
      r_active    <= 1'b1;
    end else if (r_active) begin
      if (r_cnt == CNT_LAST) begin
        r_cnt       <= '0;
        r_shift     <= {1'b1, r_shift[9:1]};
        r_bits_left <= r_bits_left - 4'd1;
        if (r_bits_left == 4'd1) r_active <= 1'b0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  // Idle line is driven from the reset-cleared active flag, so reset forces it high at once
  assign o_tx      = r_active ? r_shift[0] : 1'b1;
  assign o_bit_end = r_active && (r_cnt == CNT_LAST);
  assign o_done    = r_active && (r_bits_left == 4'd1) && (r_cnt == CNT_PRE);

endmodule

// File: rtl/midi_out_tx.sv
// MIDI OUT: one message per handshake, serialised as 8N1 frames, first start bit 2 cycles after
// acceptance; ready only in IDLE. Define MIDI_RUNNING_STATUS_EN to omit repeated channel status.
module midi_out_tx
  import midi_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 31250
) (
  input  logic          IN_CLOCK,
  input  logic          IN_RESET_N,
  midi_out_tx_if.slave  msg,
  output logic          OUT_TX,
  output logic          OUT_BUSY,
  output logic          OUT_MSG_DROPPED
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;

  state_t     r_state, w_next;
  logic [7:0] r_status;
  logic [6:0] r_data1, r_data2;
  logic       r_first;
  logic [1:0] r_byte_idx;
  logic [2:0] r_bit_idx;

  logic       w_accept, w_start, w_dropped, w_bit_end, w_done, w_skip;
  logic [1:0] w_len, w_send_idx;
  logic [7:0] w_byte;

  assign w_accept   = msg.IN_MSG_VALID && (r_state == ST_IDLE);
  assign w_len      = msg_len(r_status);
  assign w_send_idx = (r_first && w_skip) ? 2'd1 : r_byte_idx;

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] r_last_status;

  assign w_skip = is_chan_voice(r_status) && (r_status == r_last_status);

  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      r_last_status <= 8'h00;
    end else if (r_state == ST_LOAD && r_first) begin
      if (w_len == 2'd0)
        r_last_status <= 8'h00;
      else if (is_chan_voice(r_status) && !w_skip)
        r_last_status <= r_status;
    end
  end
`else
  assign w_skip = 1'b0;
`endif

  always_comb begin
    w_byte = r_status;
    case (w_send_idx)
      2'd0:    w_byte = r_status;
      2'd1:    w_byte = {1'b0, r_data1};
      default: w_byte = {1'b0, r_data2};
    endcase
  end

  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) r_state <= ST_IDLE;
    else             r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_dropped = 1'b0;
    case (r_state)
      ST_IDLE:  if (msg.IN_MSG_VALID) w_next = ST_LOAD;
      ST_LOAD: begin
        if (r_first && w_len == 2'd0) begin
          w_dropped = 1'b1;
          w_next    = ST_IDLE;
        end else begin
          w_start = 1'b1;
          w_next  = ST_START;
        end
      end
      ST_START: if (w_bit_end) w_next = ST_DATA;
      ST_DATA:  if (w_bit_end && r_bit_idx == 3'd7) w_next = ST_STOP;
      // Leave STOP during its final cycle: LOAD then overlaps it, giving gapless bytes
      ST_STOP:  if (w_done) w_next = (r_byte_idx == w_len) ? ST_IDLE : ST_LOAD;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge IN_CLOCK or negedge IN_RESET_N) begin
    if (!IN_RESET_N) begin
      r_status   <= '0;
      r_data1    <= '0;
      r_data2    <= '0;
      r_first    <= 1'b0;
      r_byte_idx <= '0;
      r_bit_idx  <= '0;
    end else begin
      if (w_accept) begin
        r_status   <= msg.IN_STATUS;
        r_data1    <= msg.IN_DATA1;
        r_data2    <= msg.IN_DATA2;
        r_first    <= 1'b1;
        r_byte_idx <= '0;
      end
      if (r_state == ST_LOAD) begin
        r_first <= 1'b0;
        if (w_start) r_byte_idx <= w_send_idx + 2'd1;
      end
      if (r_state == ST_START)
        r_bit_idx <= '0;
      else if (r_state == ST_DATA && w_bit_end)
        r_bit_idx <= r_bit_idx + 3'd1;
    end
  end

  uart_tx_byte #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart (
    .i_clk     (IN_CLOCK),
    .i_rst_n   (IN_RESET_N),
    .i_start   (w_start),
    .i_byte    (w_byte),
    .o_tx      (OUT_TX),
    .o_bit_end (w_bit_end),
    .o_done    (w_done)
  );

  assign msg.OUT_MSG_READY = (r_state == ST_IDLE);
  assign OUT_BUSY          = (r_state != ST_IDLE);
  assign OUT_MSG_DROPPED   = w_dropped;

endmodule

// File: tb/tb_midi_out_tx.sv
// Directed bench for midi_out_tx at 16 clocks per bit: table of messages plus reset/back-to-back/hold cases.
module tb_midi_out_tx;

  localparam int CPB    = 16;
  localparam int LOGN   = 16384;
  localparam int BUDGET = 3 * 10 * CPB + 50;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic tx, busy, dropped;

  midi_out_tx_if mi ();

  midi_out_tx #(.CLK_HZ(160), .BAUD(10)) dut (
    .IN_CLOCK        (clk),
    .IN_RESET_N      (rst_n),
    .msg             (mi),
    .OUT_TX          (tx),
    .OUT_BUSY        (busy),
    .OUT_MSG_DROPPED (dropped)
  );

  always #5 clk = ~clk;

  int cyc = 0, n_acc = 0, checks = 0, errors = 0;
  logic tx_log   [LOGN];
  logic rdy_log  [LOGN];
  logic busy_log [LOGN];
  logic drop_log [LOGN];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mi.IN_MSG_VALID && mi.OUT_MSG_READY) n_acc <= n_acc + 1;
  end

  // Log index k holds the value seen during the cycle after the k-th rising edge
  always @(negedge clk) begin
    if (cyc < LOGN) begin
      tx_log[cyc]   <= tx;
      rdy_log[cyc]  <= mi.OUT_MSG_READY;
      busy_log[cyc] <= busy;
      drop_log[cyc] <= dropped;
    end
  end

  typedef struct {
    logic [7:0] st;
    logic [6:0] d1;
    logic [6:0] d2;
    int         n;
    logic [7:0] b0;
    logic [7:0] b1;
    logic [7:0] b2;
  } vec_t;

  vec_t tbl [19];

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!mi.OUT_MSG_READY && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    chk("ready_wait", int'(mi.OUT_MSG_READY), 1);
  endtask

  task automatic decode(input int c, output logic [7:0] b, output int ok);
    b  = 8'h00;
    ok = 0;
    if (c + 10 * CPB <= LOGN && c >= 0) begin
      ok = (tx_log[c] == 1'b0 && tx_log[c + CPB - 1] == 1'b0 &&
            tx_log[c + 9 * CPB] == 1'b1 && tx_log[c + 10 * CPB - 1] == 1'b1) ? 1 : 0;
      for (int i = 0; i < 8; i++) b[i] = tx_log[c + (i + 1) * CPB + CPB / 2];
    end
  endtask

  task automatic check_line(input int c, input int n, input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input string tag);
    logic [7:0] got, exp;
    int ok;
    for (int j = 0; j < n; j++) begin
      exp = (j == 0) ? b0 : (j == 1) ? b1 : b2;
      decode(c + j * 10 * CPB, got, ok);
      chk($sformatf("%s_byte%0d", tag, j), int'(got), int'(exp));
      chk($sformatf("%s_frame%0d", tag, j), ok, 1);
    end
  endtask

  task automatic count_tx_low(input int from, input int upto, output int n);
    n = 0;
    for (int i = from; i < upto; i++) if (!tx_log[i]) n++;
  endtask

  task automatic run_vec(input int k);
    vec_t v;
    int acc, t, exp_low, n_low, n_busy, n_drop, n_lo, idle_from;
    string tag;
    v   = tbl[k];
    tag = $sformatf("row%0d", k);
    wait_ready();
    mi.IN_STATUS    = v.st;
    mi.IN_DATA1     = v.d1;
    mi.IN_DATA2     = v.d2;
    mi.IN_MSG_VALID = 1'b1;
    acc = cyc;
    @(negedge clk);
    mi.IN_MSG_VALID = 1'b0;
    t = 0;
    while (!mi.OUT_MSG_READY && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_done"}, int'(mi.OUT_MSG_READY), 1);
    repeat (2 * CPB) @(negedge clk);

    exp_low = (v.n == 0) ? 1 : v.n * 10 * CPB;
    n_low = 0;
    for (int i = acc + 1; i < cyc && !rdy_log[i]; i++) n_low++;
    n_busy = 0;
    n_drop = 0;
    for (int i = acc + 1; i < cyc; i++) begin
      if (busy_log[i]) n_busy++;
      if (drop_log[i]) n_drop++;
    end
    chk({tag, "_rdy_low"}, n_low, exp_low);
    chk({tag, "_busy_cyc"}, n_busy, exp_low);
    chk({tag, "_dropped"}, n_drop, (v.n == 0) ? 1 : 0);
    if (v.n == 0) chk({tag, "_drop_cycle"}, int'(drop_log[acc + 1]), 1);
    if (v.n > 0) begin
      chk({tag, "_idle_before_start"}, int'(tx_log[acc + 1]), 1);
      check_line(acc + 2, v.n, v.b0, v.b1, v.b2, tag);
    end
    idle_from = (v.n == 0) ? acc + 1 : acc + 2 + v.n * 10 * CPB;
    count_tx_low(idle_from, cyc, n_lo);
    chk({tag, "_line_idle_after"}, n_lo, 0);
  endtask

  initial begin
    int acc, acc2, t, n0, n_lo, target;

    tbl[0]  = '{8'h90, 7'h3C, 7'h64, 3, 8'h90, 8'h3C, 8'h64};
    tbl[1]  = '{8'hC1, 7'h05, 7'h00, 2, 8'hC1, 8'h05, 8'h00};
    tbl[2]  = '{8'hF8, 7'h00, 7'h00, 1, 8'hF8, 8'h00, 8'h00};
    tbl[3]  = '{8'h45, 7'h10, 7'h20, 0, 8'h00, 8'h00, 8'h00};
    tbl[4]  = '{8'hF2, 7'h01, 7'h02, 0, 8'h00, 8'h00, 8'h00};
    tbl[5]  = '{8'hE0, 7'h7F, 7'h01, 3, 8'hE0, 8'h7F, 8'h01};
    tbl[6]  = '{8'hD3, 7'h2A, 7'h00, 2, 8'hD3, 8'h2A, 8'h00};
    tbl[7]  = '{8'hB0, 7'h07, 7'h7F, 3, 8'hB0, 8'h07, 8'h7F};
    tbl[8]  = '{8'hFF, 7'h00, 7'h00, 1, 8'hFF, 8'h00, 8'h00};
    tbl[9]  = '{8'h80, 7'h3C, 7'h00, 3, 8'h80, 8'h3C, 8'h00};
    tbl[10] = '{8'h90, 7'h3C, 7'h64, 3, 8'h90, 8'h3C, 8'h64};
    tbl[12] = '{8'h80, 7'h3C, 7'h00, 3, 8'h80, 8'h3C, 8'h00};
    tbl[13] = '{8'hF8, 7'h00, 7'h00, 1, 8'hF8, 8'h00, 8'h00};
    tbl[15] = '{8'hF5, 7'h00, 7'h00, 0, 8'h00, 8'h00, 8'h00};
    tbl[16] = '{8'h80, 7'h3C, 7'h02, 3, 8'h80, 8'h3C, 8'h02};
    tbl[17] = '{8'hC5, 7'h05, 7'h00, 2, 8'hC5, 8'h05, 8'h00};
`ifdef MIDI_RUNNING_STATUS_EN
    tbl[11] = '{8'h90, 7'h40, 7'h64, 2, 8'h40, 8'h64, 8'h00};
    tbl[14] = '{8'h80, 7'h3C, 7'h01, 2, 8'h3C, 8'h01, 8'h00};
    tbl[18] = '{8'hC5, 7'h06, 7'h00, 1, 8'h06, 8'h00, 8'h00};
`else
    tbl[11] = '{8'h90, 7'h40, 7'h64, 3, 8'h90, 8'h40, 8'h64};
    tbl[14] = '{8'h80, 7'h3C, 7'h01, 3, 8'h80, 8'h3C, 8'h01};
    tbl[18] = '{8'hC5, 7'h06, 7'h00, 2, 8'hC5, 8'h06, 8'h00};
`endif

    mi.IN_MSG_VALID = 1'b0;
    mi.IN_STATUS    = 8'h00;
    mi.IN_DATA1     = 7'h00;
    mi.IN_DATA2     = 7'h00;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_tx", int'(tx), 1);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready", int'(mi.OUT_MSG_READY), 1);
    chk("rst_dropped", int'(dropped), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k <= 8; k++) run_vec(k);

    // Program change with a realtime byte queued behind it
    wait_ready();
    mi.IN_STATUS = 8'hC1; mi.IN_DATA1 = 7'h05; mi.IN_DATA2 = 7'h00;
    mi.IN_MSG_VALID = 1'b1;
    acc = cyc;
    @(negedge clk);
    t = 0;
    while (!mi.OUT_MSG_READY && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    mi.IN_STATUS = 8'hF8;
    acc2 = cyc;
    @(negedge clk);
    mi.IN_MSG_VALID = 1'b0;
    t = 0;
    while (!mi.OUT_MSG_READY && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    repeat (2 * CPB) @(negedge clk);
    chk("b2b_accept_spacing", acc2 - acc, 20 * CPB + 1);
    check_line(acc + 2, 2, 8'hC1, 8'h05, 8'h00, "b2b_pc");
    check_line(acc2 + 2, 1, 8'hF8, 8'h00, 8'h00, "b2b_rt");
    count_tx_low(acc + 2 + 20 * CPB, acc2 + 2, n_lo);
    chk("b2b_gap_high", n_lo, 0);
    chk("b2b_gap_len", (acc2 + 2) - (acc + 2 + 20 * CPB), 1);

    // Valid held with changing data while busy
    wait_ready();
    mi.IN_STATUS = 8'h90; mi.IN_DATA1 = 7'h3C; mi.IN_DATA2 = 7'h64;
    mi.IN_MSG_VALID = 1'b1;
    acc = cyc;
    n0  = n_acc;
    @(negedge clk);
    t = 0;
    while (!mi.OUT_MSG_READY && t < BUDGET) begin
      mi.IN_STATUS = 8'($urandom);
      mi.IN_DATA1  = 7'($urandom);
      mi.IN_DATA2  = 7'($urandom);
      @(negedge clk);
      t++;
    end
    mi.IN_MSG_VALID = 1'b0;
    chk("hold_rdy_low", cyc - acc - 1, 30 * CPB);
    repeat (2 * CPB) @(negedge clk);
    chk("hold_accepts", n_acc - n0, 1);
    check_line(acc + 2, 3, 8'h90, 8'h3C, 8'h64, "hold");
    count_tx_low(acc + 2 + 30 * CPB, cyc, n_lo);
    chk("hold_idle_after", n_lo, 0);

    // Reset during data bit 3 (a zero) of the second byte
    wait_ready();
    mi.IN_STATUS = 8'h92; mi.IN_DATA1 = 7'h44; mi.IN_DATA2 = 7'h64;
    mi.IN_MSG_VALID = 1'b1;
    acc = cyc;
    @(negedge clk);
    mi.IN_MSG_VALID = 1'b0;
    target = acc + 2 + 10 * CPB + 4 * CPB + CPB / 2;
    t = 0;
    while (cyc < target && t < BUDGET) begin
      @(negedge clk);
      t++;
    end
    chk("pre_rst_tx", int'(tx), 0);
    chk("pre_rst_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_tx", int'(tx), 1);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_ready", int'(mi.OUT_MSG_READY), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int k = 9; k <= 18; k++) run_vec(k);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
